// File: rtl/wave_gen_if.sv
// Configuration handshake bundle for wave_gen: valid/ready plus the offered
// mode, peak and step.
interface wave_gen_if #(
   parameter int unsigned WIDTH = 16
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_mode;
   logic [WIDTH-1:0] cfg_max;
   logic [WIDTH-1:0] cfg_step;

   modport master (
      output cfg_valid, cfg_mode, cfg_max, cfg_step,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_mode, cfg_max, cfg_step,
      output cfg_ready
   );
endinterface

// File: rtl/wave_gen.sv
// Triangle / saw-up / saw-down waveform generator with a one-deep pending
// configuration slot applied at period boundaries. WAVE_GEN_STEP_EN enables cfg_step.
module wave_gen #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned MAX_DEFAULT = 83
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   wave_gen_if.slave        cfg,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             period_start
);

   typedef enum logic [1:0] {
      MODE_TRI = 2'b00,
      MODE_UP  = 2'b01,
      MODE_DN  = 2'b10,
      MODE_RSV = 2'b11
   } mode_e;

   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             ps_q, ps_d;
   logic             ready_q, ready_d;
   mode_e            act_mode_q, act_mode_d;
   logic [WIDTH-1:0] act_max_q, act_max_d;
   mode_e            pend_mode_q, pend_mode_d;
   logic [WIDTH-1:0] pend_max_q, pend_max_d;
   logic [WIDTH-1:0] act_step;

`ifdef WAVE_GEN_STEP_EN
   logic [WIDTH-1:0] act_step_q, act_step_d;
   logic [WIDTH-1:0] pend_step_q, pend_step_d;
   assign act_step = act_step_q;
`else
   logic unused_step;
   assign act_step    = WIDTH'(1);
   assign unused_step = ^cfg.cfg_step;
`endif

   logic [WIDTH:0]   sum_c;
   logic [WIDTH-1:0] wave_cnt_c;
   logic             wave_dir_c;
   logic             wrap_c;
   logic             apply_c;

   // Free-running waveform update for the active configuration
   always_comb begin
      sum_c      = {1'b0, count_q} + {1'b0, act_step};
      wave_cnt_c = count_q;
      wave_dir_c = dir_q;
      wrap_c     = 1'b0;
      if (act_max_q == '0) begin
         wave_cnt_c = '0;
         wave_dir_c = (act_mode_q == MODE_DN);
         wrap_c     = 1'b1;
      end else begin
         case (act_mode_q)
            MODE_UP: begin
               wave_dir_c = 1'b0;
               if (count_q == act_max_q) begin
                  wave_cnt_c = '0;
                  wrap_c     = 1'b1;
               end else if (sum_c >= {1'b0, act_max_q}) begin
                  wave_cnt_c = act_max_q;
               end else begin
                  wave_cnt_c = sum_c[WIDTH-1:0];
               end
            end
            MODE_DN: begin
               wave_dir_c = 1'b1;
               if (count_q == '0) begin
                  wave_cnt_c = act_max_q;
                  wrap_c     = 1'b1;
               end else if (count_q > act_step) begin
                  wave_cnt_c = count_q - act_step;
               end else begin
                  wave_cnt_c = '0;
               end
            end
            default: begin
               if (!dir_q) begin
                  if (sum_c >= {1'b0, act_max_q}) begin
                     wave_cnt_c = act_max_q;
                     wave_dir_c = 1'b1;
                  end else begin
                     wave_cnt_c = sum_c[WIDTH-1:0];
                  end
               end else if (count_q <= act_step) begin
                  wave_cnt_c = '0;
                  wave_dir_c = 1'b0;
                  wrap_c     = 1'b1;
               end else begin
                  wave_cnt_c = count_q - act_step;
               end
            end
         endcase
      end
   end

   // Slot application overrides the waveform; otherwise accept a new offer
   always_comb begin
      count_d     = count_q;
      dir_d       = dir_q;
      ps_d        = 1'b0;
      ready_d     = ready_q;
      act_mode_d  = act_mode_q;
      act_max_d   = act_max_q;
      pend_mode_d = pend_mode_q;
      pend_max_d  = pend_max_q;
`ifdef WAVE_GEN_STEP_EN
      act_step_d  = act_step_q;
      pend_step_d = pend_step_q;
`endif
      apply_c = !ready_q && (!enable || wrap_c);
      if (apply_c) begin
         act_mode_d = pend_mode_q;
         act_max_d  = pend_max_q;
`ifdef WAVE_GEN_STEP_EN
         act_step_d = pend_step_q;
`endif
         count_d    = (pend_mode_q == MODE_DN) ? pend_max_q : '0;
         dir_d      = (pend_mode_q == MODE_DN);
         ps_d       = 1'b1;
         ready_d    = 1'b1;
      end else begin
         if (enable) begin
            count_d = wave_cnt_c;
            dir_d   = wave_dir_c;
            ps_d    = wrap_c;
         end
         if (ready_q && cfg.cfg_valid) begin
            pend_mode_d = mode_e'(cfg.cfg_mode);
            pend_max_d  = cfg.cfg_max;
`ifdef WAVE_GEN_STEP_EN
            pend_step_d = (cfg.cfg_step == '0) ? WIDTH'(1) : cfg.cfg_step;
`endif
            ready_d     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q     <= '0;
         dir_q       <= 1'b0;
         ps_q        <= 1'b0;
         ready_q     <= 1'b1;
         act_mode_q  <= MODE_TRI;
         act_max_q   <= WIDTH'(MAX_DEFAULT);
         pend_mode_q <= MODE_TRI;
         pend_max_q  <= '0;
      end else begin
         count_q     <= count_d;
         dir_q       <= dir_d;
         ps_q        <= ps_d;
         ready_q     <= ready_d;
         act_mode_q  <= act_mode_d;
         act_max_q   <= act_max_d;
         pend_mode_q <= pend_mode_d;
         pend_max_q  <= pend_max_d;
      end
   end

`ifdef WAVE_GEN_STEP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         act_step_q  <= WIDTH'(1);
         pend_step_q <= WIDTH'(1);
      end else begin
         act_step_q  <= act_step_d;
         pend_step_q <= pend_step_d;
      end
   end
`endif

   assign count         = count_q;
   assign dir           = dir_q;
   assign period_start  = ps_q;
   assign cfg.cfg_ready = ready_q;

endmodule

// File: tb/tb_wave_gen.sv
// Bench for wave_gen: hand-written vector table, directed corner sequences and
// random traffic checked against a per-period sample-sequence model.
module tb_wave_gen;

   localparam int unsigned W = 16;

   logic         clk;
   logic         reset;
   logic         enable;
   logic [W-1:0] count;
   logic         dir;
   logic         period_start;

   wave_gen_if #(.WIDTH(W)) cfg_if ();

   wave_gen #(.WIDTH(W), .MAX_DEFAULT(83)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .cfg          (cfg_if),
      .count        (count),
      .dir          (dir),
      .period_start (period_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass  = 0;
   int n_total = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endfunction

   // ---------------- reference model: queue of upcoming samples ----------------
   typedef struct packed {
      logic [W-1:0] c;
      logic         d;
      logic         p;
   } sample_t;

   sample_t      fut[$];
   logic [W-1:0] m_count;
   logic         m_dir, m_ps, m_ready;
   logic [1:0]   a_mode, p_mode;
   logic [W-1:0] a_max, p_max, a_step, p_step;

   function automatic int eff_step(logic [W-1:0] st);
`ifdef WAVE_GEN_STEP_EN
      return (st == '0) ? 1 : int'(st);
`else
      return 1;
`endif
   endfunction

   function automatic void push(int c, bit d, bit p);
      sample_t s;
      s.c = W'(c);
      s.d = d;
      s.p = p;
      fut.push_back(s);
   endfunction

   // One full period of samples following the start value, ending on the boundary
   function automatic void gen_period();
      int mx, st, v;
      mx = int'(a_max);
      st = eff_step(a_step);
      if (mx == 0) begin
         push(0, a_mode == 2'd2, 1'b1);
         return;
      end
      case (a_mode)
         2'd1: begin
            v = 0;
            while (v != mx) begin
               v = (v + st > mx) ? mx : v + st;
               push(v, 1'b0, 1'b0);
            end
            push(0, 1'b0, 1'b1);
         end
         2'd2: begin
            v = mx;
            while (v != 0) begin
               v = (v > st) ? v - st : 0;
               push(v, 1'b1, 1'b0);
            end
            push(mx, 1'b1, 1'b1);
         end
         default: begin
            v = 0;
            while (v + st < mx) begin
               v = v + st;
               push(v, 1'b0, 1'b0);
            end
            push(mx, 1'b1, 1'b0);
            v = mx;
            while (v > st) begin
               v = v - st;
               push(v, 1'b1, 1'b0);
            end
            push(0, 1'b0, 1'b1);
         end
      endcase
   endfunction

   function automatic void model_reset();
      m_count = '0; m_dir = 1'b0; m_ps = 1'b0; m_ready = 1'b1;
      a_mode = 2'd0; a_max = W'(83); a_step = W'(1);
      p_mode = 2'd0; p_max = '0; p_step = W'(1);
      fut.delete();
      gen_period();
   endfunction

   function automatic void model_edge();
      sample_t s;
      if (!m_ready && (!enable || fut[0].p)) begin
         a_mode = p_mode; a_max = p_max; a_step = p_step;
         m_count = (p_mode == 2'd2) ? p_max : '0;
         m_dir   = (p_mode == 2'd2);
         m_ps    = 1'b1;
         m_ready = 1'b1;
         fut.delete();
         gen_period();
      end else begin
         if (enable) begin
            s = fut.pop_front();
            m_count = s.c; m_dir = s.d; m_ps = s.p;
            if (fut.size() == 0) gen_period();
         end else begin
            m_ps = 1'b0;
         end
         if (m_ready && cfg_if.cfg_valid) begin
            p_mode = cfg_if.cfg_mode; p_max = cfg_if.cfg_max; p_step = cfg_if.cfg_step;
            m_ready = 1'b0;
         end
      end
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      chk("count",        count,            m_count);
      chk("dir",          dir,              m_dir);
      chk("period_start", period_start,     m_ps);
      chk("cfg_ready",    cfg_if.cfg_ready, m_ready);
   endtask

   task automatic do_reset();
      cfg_if.cfg_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_dir", dir, 0);
      chk("rst_ps", period_start, 0);
      chk("rst_ready", cfg_if.cfg_ready, 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_hold_count", count, 0);
      chk("rst_hold_ready", cfg_if.cfg_ready, 1);
      #2 reset = 1'b1;
      model_reset();
   endtask

   // Hold an offer until the slot takes it, bounded
   task automatic offer(logic [1:0] m, logic [W-1:0] mx, logic [W-1:0] st);
      bit done;
      done = 1'b0;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_mode  = m;
      cfg_if.cfg_max   = mx;
      cfg_if.cfg_step  = st;
      for (int i = 0; i < 400 && !done; i++) begin
         done = m_ready;
         cycle();
      end
      cfg_if.cfg_valid = 1'b0;
      if (!done) begin
         n_total++;
         $display("FAIL offer_timeout: offer mode %0d max %0d not taken in 400 cycles", m, mx);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit           en;
      bit           vld;
      logic [1:0]   mode;
      logic [W-1:0] mx;
      logic [W-1:0] st;
      logic [W-1:0] c;
      bit           d;
      bit           p;
      bit           r;
   } vec_t;

   function automatic vec_t mk(bit en, bit vld, int mode, int mx, int c, bit d, bit p, bit r);
      vec_t v;
      v.en = en; v.vld = vld; v.mode = 2'(mode); v.mx = W'(mx); v.st = W'(1);
      v.c = W'(c); v.d = d; v.p = p; v.r = r;
      return v;
   endfunction

   vec_t tbl[12];
   int   exp_sd[6];

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_mode = 2'd0;
      cfg_if.cfg_max = '0;
      cfg_if.cfg_step = '0;

      // Load triangle max=3 while disabled, then run: 0,1,2,3,2,1,0,1,...
      tbl[0]  = mk(0, 1, 0, 3, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 3, 0, 0, 1, 1);
      tbl[2]  = mk(1, 0, 0, 3, 1, 0, 0, 1);
      tbl[3]  = mk(1, 0, 0, 3, 2, 0, 0, 1);
      tbl[4]  = mk(1, 0, 0, 3, 3, 1, 0, 1);
      tbl[5]  = mk(1, 0, 0, 3, 2, 1, 0, 1);
      tbl[6]  = mk(1, 0, 0, 3, 1, 1, 0, 1);
      tbl[7]  = mk(1, 0, 0, 3, 0, 0, 1, 1);
      tbl[8]  = mk(1, 0, 0, 3, 1, 0, 0, 1);
      tbl[9]  = mk(1, 0, 0, 3, 2, 0, 0, 1);
      tbl[10] = mk(0, 0, 0, 3, 2, 0, 0, 1);
      tbl[11] = mk(1, 0, 0, 3, 3, 1, 0, 1);

`ifdef WAVE_GEN_STEP_EN
      exp_sd = '{5, 3, 1, 0, 5, 3};
`else
      exp_sd = '{5, 4, 3, 2, 1, 0};
`endif

      do_reset();

      for (int i = 0; i < 12; i++) begin
         enable           = tbl[i].en;
         cfg_if.cfg_valid = tbl[i].vld;
         cfg_if.cfg_mode  = tbl[i].mode;
         cfg_if.cfg_max   = tbl[i].mx;
         cfg_if.cfg_step  = tbl[i].st;
         @(posedge clk);
         #1;
         chk("tbl_count", count, tbl[i].c);
         chk("tbl_dir", dir, tbl[i].d);
         chk("tbl_ps", period_start, tbl[i].p);
         chk("tbl_ready", cfg_if.cfg_ready, tbl[i].r);
      end
      cfg_if.cfg_valid = 1'b0;

      // Reset default triangle, 200 enabled cycles, period 166
      do_reset();
      enable = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         int ph;
         cycle();
         ph = k % 166;
         chk("def_tri_count", count, (ph <= 83) ? ph : 166 - ph);
         chk("def_tri_dir", dir, (ph >= 83) ? 1 : 0);
         chk("def_tri_ps", period_start, (ph == 0) ? 1 : 0);
      end

      // Saw-down max=5 step=2 offered mid-triangle; takes over at the boundary
      offer(2'd2, W'(5), W'(2));
      for (int i = 0; i < 300; i++) begin
         if (period_start) break;
         cycle();
      end
      chk("sd_first_ps", period_start, 1);
      chk("sd_first_count", count, exp_sd[0]);
      chk("sd_first_dir", dir, 1);
      for (int i = 1; i < 6; i++) begin
         cycle();
         chk("sd_seq_count", count, exp_sd[i]);
      end

      // Back-to-back offers: second waits for the slot to drain
      offer(2'd0, W'(4), W'(1));
      chk("b2b_ready_low", cfg_if.cfg_ready, 0);
      offer(2'd1, W'(6), W'(0));
      for (int i = 0; i < 4; i++) cycle();

      // Disabled: pending applies next edge; saw-up max=0 pins count at 0
      enable = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      offer(2'd1, W'(0), W'(1));
      cycle();
      chk("max0_applied_ps", period_start, 1);
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("max0_count", count, 0);
         chk("max0_ps", period_start, 1);
      end

      // Reset mid falling slope with the slot full discards the pending config
      enable = 1'b0;
      offer(2'd0, W'(20), W'(1));
      cycle();
      enable = 1'b1;
      for (int i = 0; i < 25; i++) cycle();
      chk("pre_rst_dir", dir, 1);
      offer(2'd1, W'(9), W'(1));
      chk("pre_rst_ready", cfg_if.cfg_ready, 0);
      cycle();
      cycle();
      do_reset();
      cycle();
      chk("post_rst_first", count, 1);
      for (int i = 0; i < 200; i++) cycle();

      // Random enable / offers against the model
      for (int i = 0; i < 3000; i++) begin
         bit acc;
         enable = ($urandom_range(0, 9) != 0);
         if (!cfg_if.cfg_valid && $urandom_range(0, 7) == 0) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_mode  = 2'($urandom_range(0, 3));
            cfg_if.cfg_max   = W'($urandom_range(0, 40));
            cfg_if.cfg_step  = W'($urandom_range(0, 6));
         end
         acc = cfg_if.cfg_valid && m_ready;
         cycle();
         if (acc) cfg_if.cfg_valid = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
